// File: rtl/ntt_ctrl_if.sv
// Handshake and memory/butterfly bus of the NTT sequencer.
// master = controller side, slave = memories, twiddle ROM and butterfly unit.
interface ntt_ctrl_if #(
    parameter int bit_len = 23,
    parameter int LOGN    = 8
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [LOGN-1:0]           rd_addr_a;
    logic [LOGN-1:0]           rd_addr_b;
    logic signed [bit_len-1:0] rd_data_a;
    logic signed [bit_len-1:0] rd_data_b;
    logic [LOGN-1:0]           zeta_addr;
    logic signed [bit_len-1:0] zeta_data;
    logic                      we;
    logic [LOGN-1:0]           wr_addr_a;
    logic [LOGN-1:0]           wr_addr_b;
    logic signed [bit_len-1:0] wr_data_a;
    logic signed [bit_len-1:0] wr_data_b;
    logic                      bt_rst_n;
    logic                      bt_en;
    logic signed [bit_len-1:0] bt_a;
    logic signed [bit_len-1:0] bt_b;
    logic signed [bit_len-1:0] bt_zeta;
    logic signed [bit_len-1:0] bt_a_res;
    logic signed [bit_len-1:0] bt_b_res;
    logic                      bt_valid;

    modport master (
        input  start, rd_data_a, rd_data_b, zeta_data, bt_a_res, bt_b_res, bt_valid,
        output busy, done, err, rd_addr_a, rd_addr_b, zeta_addr, we,
               wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
               bt_rst_n, bt_en, bt_a, bt_b, bt_zeta
    );

    modport slave (
        output start, rd_data_a, rd_data_b, zeta_data, bt_a_res, bt_b_res, bt_valid,
        input  busy, done, err, rd_addr_a, rd_addr_b, zeta_addr, we,
               wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
               bt_rst_n, bt_en, bt_a, bt_b, bt_zeta
    );
endinterface

// File: rtl/ntt_ctrl.sv
// Forward-NTT sequencer: walks layers/groups/pairs, feeds an external butterfly, writes results back.
// Optional RUN watchdog with abort flag: define NTT_CTRL_TIMEOUT_EN.
module ntt_ctrl #(
    parameter int bit_len = 23,
    parameter int N       = 256,
    parameter int LOGN    = 8
) (
    input  logic       clk,
    input  logic       reset,
    ntt_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_CLR  = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [LOGN:0]   C_N    = (LOGN+1)'(N);
    localparam logic [LOGN-1:0] C_HALF = LOGN'(N/2);

    logic [2:0]                r_state;
    logic [LOGN-1:0]           r_len;
    logic [LOGN-1:0]           r_grp;
    logic [LOGN-1:0]           r_j;
    logic [LOGN-1:0]           r_k;
    logic signed [bit_len-1:0] r_bt_a;
    logic signed [bit_len-1:0] r_bt_b;
    logic signed [bit_len-1:0] r_bt_zeta;
`ifdef NTT_CTRL_TIMEOUT_EN
    logic [3:0]                r_wdog;
    logic                      r_err;
`endif

    logic [LOGN:0]   w_j_inc;
    logic [LOGN:0]   w_grp_next;
    logic [LOGN-1:0] w_len_half;
    logic [LOGN-1:0] w_addr_a;
    logic [LOGN-1:0] w_addr_b;
    logic            w_j_last;
    logic            w_grp_end;
    logic            w_finish;
    logic            w_active;
    logic            w_wr;

    // Index arithmetic one bit wider so grp+2*len can reach N without wrapping.
    assign w_j_inc    = {1'b0, r_j} + (LOGN+1)'(1);
    assign w_j_last   = (w_j_inc == {1'b0, r_len});
    assign w_grp_next = {1'b0, r_grp} + {r_len, 1'b0};
    assign w_grp_end  = w_j_last && (w_grp_next == C_N);
    assign w_len_half = r_len >> 1;
    assign w_finish   = w_grp_end && (w_len_half == '0);
    assign w_addr_a   = r_grp + r_j;
    assign w_addr_b   = w_addr_a + r_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_grp     <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_bt_a    <= '0;
            r_bt_b    <= '0;
            r_bt_zeta <= '0;
`ifdef NTT_CTRL_TIMEOUT_EN
            r_wdog    <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RD;
                        r_len   <= C_HALF;
                        r_grp   <= '0;
                        r_j     <= '0;
                        r_k     <= LOGN'(1);
`ifdef NTT_CTRL_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_RD: r_state <= S_LAT;
                S_LAT: begin
                    r_bt_a    <= bus.rd_data_a;
                    r_bt_b    <= bus.rd_data_b;
                    r_bt_zeta <= bus.zeta_data;
                    r_state   <= S_CLR;
                end
                S_CLR: begin
`ifdef NTT_CTRL_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.bt_valid) begin
                        r_state <= S_WR;
                    end
`ifdef NTT_CTRL_TIMEOUT_EN
                    else if (r_wdog == 4'hF) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wdog  <= r_wdog + 4'd1;
                    end
`endif
                end
                S_WR: begin
                    if (!w_j_last) begin
                        r_j <= w_j_inc[LOGN-1:0];
                    end else begin
                        r_j <= '0;
                        if (!w_grp_end) begin
                            r_grp <= w_grp_next[LOGN-1:0];
                        end else begin
                            r_grp <= '0;
                            r_len <= w_len_half;
                        end
                        // Last group of the last layer leaves k at N-1.
                        if (!w_finish) begin
                            r_k <= r_k + LOGN'(1);
                        end
                    end
                    r_state <= w_finish ? S_DONE : S_RD;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_active = (r_state == S_RD) || (r_state == S_LAT) || (r_state == S_CLR) ||
                      (r_state == S_RUN) || (r_state == S_WR);
    assign w_wr     = (r_state == S_WR);

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.rd_addr_a = w_active ? w_addr_a : '0;
    assign bus.rd_addr_b = w_active ? w_addr_b : '0;
    assign bus.zeta_addr = w_active ? r_k : '0;
    assign bus.we        = w_wr;
    assign bus.wr_addr_a = w_wr ? w_addr_a : '0;
    assign bus.wr_addr_b = w_wr ? w_addr_b : '0;
    assign bus.wr_data_a = w_wr ? bus.bt_a_res : '0;
    assign bus.wr_data_b = w_wr ? bus.bt_b_res : '0;
    assign bus.bt_rst_n  = reset & (r_state != S_CLR);
    assign bus.bt_en     = (r_state == S_RUN);
    assign bus.bt_a      = r_bt_a;
    assign bus.bt_b      = r_bt_b;
    assign bus.bt_zeta   = r_bt_zeta;
`ifdef NTT_CTRL_TIMEOUT_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif
endmodule
